trng_out_packer: RTL and testbench
==================================

TRNG_OUT_PACKER -- requirements
Module: trng_out_packer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, output word width in bits (8..64).
REQ-002 The module SHALL have parameter DEPTH, default 4, output FIFO depth in words (power of two, 2..16).
REQ-003 The module SHALL have parameter RCT_CUTOFF, default 32, repetition-count health-test cutoff (2..63).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_en  input  1  keystream bit qualifier, driven by the generator FSM output enable.
REQ-007 in_bit  input  1  keystream bit; sampled only when in_en=1.
REQ-008 flush  input  1  synchronous clear of packer, FIFO and health state.
REQ-009 out_data  output  WIDTH  word at FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-012 fifo_level  output  $clog2(DEPTH)+1  words currently stored.
REQ-013 drop_cnt  output  16  count of completed words discarded because the FIFO was full; saturates at 0xFFFF.
REQ-014 health_fail  output  1  sticky repetition-count failure flag.

Function
REQ-015 A bit SHALL be accepted on each cycle with in_en=1, flush=0 and health_fail=0; otherwise packer state SHALL hold.
REQ-016 Accepted bits SHALL pack LSB-first: the k-th accepted bit of a word (k=0..WIDTH-1) SHALL land in bit k.
REQ-017 A bit counter SHALL count 0..WIDTH-1 and wrap to 0 on acceptance of bit WIDTH-1 (word completion).
REQ-018 On completion the word SHALL be written to the FIFO in the same edge; it SHALL appear on out_data/out_valid one cycle after the last bit is accepted if the FIFO was empty.
REQ-019 A pop SHALL occur on each edge with out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Completion with FIFO full and no pop on the same edge SHALL discard the word and increment drop_cnt (saturating); FIFO contents SHALL be unchanged.
REQ-021 Completion with FIFO full and a pop on the same edge SHALL store the word; fifo_level SHALL stay DEPTH.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_level unchanged.
REQ-023 Health test: a run counter SHALL track consecutive identical accepted bits, set to 1 on the first bit after reset/flush or on any bit differing from the previous accepted bit.
REQ-024 When the run counter reaches RCT_CUTOFF, health_fail SHALL be set on that edge and remain set until rst or flush.
REQ-025 If health failure and word completion occur on the same edge, the word SHALL be discarded without incrementing drop_cnt.
REQ-026 While health_fail=1, no new words SHALL enter the FIFO; words already stored SHALL remain poppable.
REQ-027 flush=1 SHALL, on the next edge, empty the FIFO, zero the bit counter, shift register, run counter and health_fail; drop_cnt SHALL be retained.
REQ-028 flush SHALL take priority over a coincident accept, push or pop; the coincident bit and pop SHALL be discarded.

Reset
REQ-029 rst=1 SHALL asynchronously clear: FIFO pointers, fifo_level=0, out_valid=0, out_data=0, bit counter=0, shift register=0, run counter=0, drop_cnt=0, health_fail=0.
REQ-030 rst asserted mid-word or mid-transfer SHALL discard all partial and stored data; first accepted bit after release SHALL be bit 0 of a new word.

Verification
REQ-031 Accept 32 bits 1,0,1,0,... with out_ready=1 -> out_valid=1 one cycle after bit 32, out_data=0x55555555, fifo_level returns to 0 after pop.
REQ-032 out_ready=0, accept 5 words of alternating bits -> fifo_level=4, drop_cnt=1; then out_ready=1 -> four words drain in order, out_valid=0 after.
REQ-033 FIFO full, out_ready=1 on the edge completing word 5 -> fifo_level stays 4, drop_cnt=0, word 5 emerges last.
REQ-034 Accept 32 consecutive 1s -> health_fail=1 after bit 32, no word pushed, drop_cnt unchanged; flush -> health_fail=0, packing resumes.
REQ-035 Accept 10 bits, pulse flush, accept 32 bits 0xA5A5A5A5 LSB-first (runs of at most two identical bits) -> single word 0xA5A5A5A5 delivered.
REQ-036 Assert rst for one cycle with 2 words stored and 7 bits pending -> all outputs zero, next 32 accepted bits form one fresh word.

Source files
------------

// File: rtl/trng_out_packer_if.sv
// Bundle of the keystream-input and word-output signals of the TRNG output packer.
// The slave modport is the packer's view; the master modport is the generator/consumer side.
interface trng_out_packer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);

  // Keystream side
  logic                     in_en;
  logic                     in_bit;
  logic                     flush;

  // Word output side
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;

  // Status
  logic [$clog2(DEPTH):0]   fifo_level;
  logic [15:0]              drop_cnt;
  logic                     health_fail;

  modport slave (
    input  in_en,
    input  in_bit,
    input  flush,
    input  out_ready,
    output out_data,
    output out_valid,
    output fifo_level,
    output drop_cnt,
    output health_fail
  );

  modport master (
    output in_en,
    output in_bit,
    output flush,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  fifo_level,
    input  drop_cnt,
    input  health_fail
  );

endinterface

// File: rtl/trng_out_packer.sv
// TRNG output packer: packs qualified keystream bits LSB-first into WIDTH-bit words,
// buffers them in a small FIFO, and runs a repetition-count health test that
// blocks further output once a run of identical bits reaches RCT_CUTOFF.
module trng_out_packer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic               clk,
  input  logic               rst,
  trng_out_packer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [5:0]    CUTOFF    = 6'(RCT_CUTOFF);

  // Packer and health-test state
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [5:0]       run_cnt;
  logic             prev_bit;
  logic             health_fail;
  logic [15:0]      drop_cnt;

  // FIFO state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  // Per-cycle decisions
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] word;
  logic [5:0]       run_next;
  logic             health_hit;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;

  assign accept     = bus.in_en && !bus.flush && !health_fail;
  assign last_bit   = (bit_cnt == LAST_BIT);
  // Bits enter at the MSB and shift right, so the first bit of a word ends in bit 0.
  assign word       = {bus.in_bit, shift_reg[WIDTH-1:1]};
  assign health_hit = accept && (run_next == CUTOFF);
  // A word completing on the same edge as a health failure is silently discarded.
  assign push_req   = accept && last_bit && !health_hit;
  assign pop        = bus.out_valid && bus.out_ready && !bus.flush;
  assign full       = (level == FULL_LVL);
  assign push       = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  // Next value of the repetition counter for the bit currently offered.
  always_comb begin
    // NOTE: default assigned first so every path drives run_next and no latch is inferred.
    run_next = 6'd1;
    if (run_cnt != 6'd0 && bus.in_bit == prev_bit) begin
      run_next = run_cnt + 6'd1;
    end
  end

  // Bit packer and repetition-count health test.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
    if (rst) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      run_cnt     <= '0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (bus.flush) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      run_cnt     <= '0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (accept) begin
      bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
      shift_reg <= last_bit ? '0 : word;
      run_cnt   <= run_next;
      prev_bit  <= bus.in_bit;
      if (health_hit) begin
        health_fail <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; on a full push+pop the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; out_data is masked while empty so stale entries are never visible.
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Saturating count of completed words lost to a full FIFO; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.out_valid   = (level != '0);
  assign bus.out_data    = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.fifo_level  = level;
  assign bus.drop_cnt    = drop_cnt;
  assign bus.health_fail = health_fail;

endmodule

// File: tb/tb_trng_out_packer.sv
// Directed testbench for trng_out_packer: packing, FIFO back-pressure and drops,
// full push+pop, health-test lockout, flush and mid-word reset.
module tb_trng_out_packer;

  localparam int WIDTH      = 32;
  localparam int DEPTH      = 4;
  localparam int RCT_CUTOFF = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [5];
  logic [31:0] held;

  trng_out_packer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  trng_out_packer #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RCT_CUTOFF (RCT_CUTOFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one bit per cycle, LSB first; out_ready takes rdy_last for the final bit.
  task automatic send_bits(input logic [31:0] w, input int n, input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      bus.in_en  = 1'b1;
      bus.in_bit = w[i];
      if (i == n - 1) bus.out_ready = rdy_last;
      tick();
    end
    bus.in_en  = 1'b0;
    bus.in_bit = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"},  64'(bus.out_valid),   64'd0);
    check({tag, ".data"},   64'(bus.out_data),    64'd0);
    check({tag, ".level"},  64'(bus.fifo_level),  64'd0);
    check({tag, ".drop"},   64'(bus.drop_cnt),    64'd0);
    check({tag, ".health"}, 64'(bus.health_fail), 64'd0);
  endtask

  initial begin
    words[0] = 32'h55555555;
    words[1] = 32'hAAAAAAAA;
    words[2] = 32'h33333333;
    words[3] = 32'hCCCCCCCC;
    words[4] = 32'h66666666;

    bus.in_en     = 1'b0;
    bus.in_bit    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check_idle("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single word, consumer ready
    bus.out_ready = 1'b1;
    send_bits(32'h55555555, 32, 1'b1);
    check("w1.valid", 64'(bus.out_valid),  64'd1);
    check("w1.data",  64'(bus.out_data),   64'h55555555);
    check("w1.level", 64'(bus.fifo_level), 64'd1);
    tick();
    check("w1.level_after_pop", 64'(bus.fifo_level), 64'd0);
    check("w1.valid_after_pop", 64'(bus.out_valid),  64'd0);

    // Back-pressure: five words into a four-deep FIFO, fifth dropped
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_bits(words[k], 32, 1'b0);
    check("bp.level", 64'(bus.fifo_level), 64'd4);
    check("bp.drop",  64'(bus.drop_cnt),   64'd1);
    held = bus.out_data;
    tick();
    check("bp.stable", 64'(bus.out_data), 64'(held));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp.drain%0d", k), 64'(bus.out_data), 64'(words[k]));
      tick();
    end
    check("bp.empty_valid", 64'(bus.out_valid),  64'd0);
    check("bp.empty_level", 64'(bus.fifo_level), 64'd0);

    // Full FIFO with a pop on the completing edge: word stored, no drop
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_bits(words[k], 32, 1'b0);
    check("fp.level_full", 64'(bus.fifo_level), 64'd4);
    send_bits(words[4], 32, 1'b1);
    check("fp.level", 64'(bus.fifo_level), 64'd4);
    check("fp.drop",  64'(bus.drop_cnt),   64'd1);
    for (int k = 1; k < 5; k++) begin
      check($sformatf("fp.drain%0d", k), 64'(bus.out_data), 64'(words[k]));
      tick();
    end
    check("fp.empty_valid", 64'(bus.out_valid), 64'd0);

    // Health test: 32 identical bits trip the flag and the word is discarded
    send_bits(32'hFFFFFFFF, 32, 1'b1);
    check("ht.fail",  64'(bus.health_fail), 64'd1);
    check("ht.valid", 64'(bus.out_valid),   64'd0);
    check("ht.drop",  64'(bus.drop_cnt),    64'd1);
    send_bits(32'h12345678, 32, 1'b1);
    check("ht.locked_level", 64'(bus.fifo_level),  64'd0);
    check("ht.still_failed", 64'(bus.health_fail), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("ht.flush_clears", 64'(bus.health_fail), 64'd0);
    send_bits(32'h12345678, 32, 1'b1);
    check("ht.resume_valid", 64'(bus.out_valid), 64'd1);
    check("ht.resume_data",  64'(bus.out_data),  64'h12345678);
    tick();

    // Partial word, flush with a coincident bit, then a clean word
    send_bits(32'h0000015A, 10, 1'b1);
    bus.flush  = 1'b1;
    bus.in_en  = 1'b1;
    bus.in_bit = 1'b1;
    tick();
    bus.flush  = 1'b0;
    bus.in_en  = 1'b0;
    bus.in_bit = 1'b0;
    check("fl.level", 64'(bus.fifo_level), 64'd0);
    send_bits(32'hA5A5A5A5, 32, 1'b1);
    check("fl.valid", 64'(bus.out_valid), 64'd1);
    check("fl.data",  64'(bus.out_data),  64'hA5A5A5A5);
    tick();
    check("fl.single", 64'(bus.out_valid), 64'd0);

    // Reset with two words stored and seven bits pending
    bus.out_ready = 1'b0;
    send_bits(words[0], 32, 1'b0);
    send_bits(words[1], 32, 1'b0);
    send_bits(32'h0000007F, 7, 1'b0);
    check("rs.level_before", 64'(bus.fifo_level), 64'd2);
    rst = 1'b1;
    #1;
    check_idle("rs.async");
    tick();
    rst = 1'b0;
    check_idle("rs.after");
    send_bits(32'hDEADBEEF, 32, 1'b0);
    check("rs.fresh_level", 64'(bus.fifo_level), 64'd1);
    check("rs.fresh_data",  64'(bus.out_data),   64'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
